// File: rtl/mux_pkg.sv
// Shared constants for the registered N:1 multiplexer pipeline.
//   DefaultWidth : default channel / output data width
//   MaxN         : largest supported channel count
//   XferCntW     : width of the output-transfer counter
package mux_pkg;

  localparam int unsigned DefaultWidth = 5;
  localparam int unsigned MaxN         = 16;
  localparam int unsigned XferCntW     = 16;

endpackage

// File: rtl/skid_buf.sv
// Two-entry (main + skid) valid/ready buffer with a registered in_ready.
// Ports:
//   clk_i, rst_i                    clock, asynchronous active-high reset
//   in_valid_i / in_ready_o         upstream handshake (in_ready_o is a flop)
//   in_payload_i                    payload captured on an input transfer
//   out_valid_o / out_ready_i       downstream handshake
//   out_payload_o                   head-of-line payload (main entry)
module skid_buf #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [Width-1:0] in_payload_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [Width-1:0] out_payload_o
);

  logic             main_valid_q, main_valid_d;
  logic             skid_valid_q, skid_valid_d;
  logic [Width-1:0] main_q, main_d;
  logic [Width-1:0] skid_q, skid_d;
  logic             rdy_q, rdy_d;
  logic             in_fire;
  logic             out_fire;

  assign in_fire  = in_valid_i & rdy_q;
  assign out_fire = main_valid_q & out_ready_i;

  always_comb begin
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    main_d       = main_q;
    skid_d       = skid_q;
    if (skid_valid_q) begin
      // rdy_q is low here, so only the drain path can act.
      if (out_ready_i) begin
        main_d       = skid_q;
        skid_valid_d = 1'b0;
      end
    end else if (in_fire) begin
      if (!main_valid_q || out_fire) begin
        main_d       = in_payload_i;
        main_valid_d = 1'b1;
      end else begin
        skid_d       = in_payload_i;
        skid_valid_d = 1'b1;
      end
    end else if (out_fire) begin
      main_valid_d = 1'b0;
    end
    rdy_d = ~skid_valid_d;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      main_q       <= '0;
      skid_q       <= '0;
      rdy_q        <= 1'b0;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      main_q       <= main_d;
      skid_q       <= skid_d;
      rdy_q        <= rdy_d;
    end
  end

  assign in_ready_o    = rdy_q;
  assign out_valid_o   = main_valid_q;
  assign out_payload_o = main_q;

endmodule

// File: rtl/mux_n_1_reg_pipe.sv
// Registered N:1 multiplexer with valid/ready handshakes on both sides.
// The selected channel and its select index are captured into a two-entry
// skid buffer; out-of-range selects yield zero data and set a sticky error.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   in_valid / in_ready   upstream handshake (in_ready registered)
//   sel, data             channel index and packed channels (k at [k*WIDTH +: WIDTH])
//   out_valid / out_ready downstream handshake
//   out_data, out_sel     selected value and the select that produced it
//   sel_err               sticky: an accepted sel was >= N
//   xfer_cnt              wrapping count of output transfers
module mux_n_1_reg_pipe
  import mux_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth,
  parameter int unsigned N     = 2,
  parameter int unsigned SELW  = $clog2(N)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [SELW-1:0]     sel,
  input  logic [N*WIDTH-1:0]  data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WIDTH-1:0]    out_data,
  output logic [SELW-1:0]     out_sel,
  output logic                sel_err,
  output logic [XferCntW-1:0] xfer_cnt
);

  localparam int unsigned PayW = WIDTH + SELW;

  logic             sel_hit;
  logic [WIDTH-1:0] sel_data;
  logic [PayW-1:0]  in_payload;
  logic [PayW-1:0]  out_payload;
  logic             in_fire;
  logic             out_fire;
  logic                sel_err_q, sel_err_d;
  logic [XferCntW-1:0] xfer_cnt_q, xfer_cnt_d;

  // Compare against each legal index so an out-of-range sel never indexes data.
  always_comb begin
    sel_hit  = 1'b0;
    sel_data = '0;
    for (int k = 0; k < int'(N); k++) begin
      if (sel == SELW'(k)) begin
        sel_hit  = 1'b1;
        sel_data = data[k*WIDTH +: WIDTH];
      end
    end
  end

  assign in_payload = {sel, sel_data};

  skid_buf #(
    .Width(PayW)
  ) u_skid_buf (
    .clk_i        (clk),
    .rst_i        (rst),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready),
    .in_payload_i (in_payload),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .out_payload_o(out_payload)
  );

  assign out_sel  = out_payload[PayW-1:WIDTH];
  assign out_data = out_payload[WIDTH-1:0];

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  always_comb begin
    sel_err_d  = sel_err_q | (in_fire & ~sel_hit);
    xfer_cnt_d = out_fire ? xfer_cnt_q + 1'b1 : xfer_cnt_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_err_q  <= 1'b0;
      xfer_cnt_q <= '0;
    end else begin
      sel_err_q  <= sel_err_d;
      xfer_cnt_q <= xfer_cnt_d;
    end
  end

  assign sel_err  = sel_err_q;
  assign xfer_cnt = xfer_cnt_q;

endmodule
